coin_credit_tx: RTL and testbench

Front end that turns the three raw coin switches (sw0 = 5, sw1 = 10, sw2 = 20 units) into clean, one-shot credit transactions. It synchronises and debounces each switch and detects rising edges. Pending coins are queued per switch and presented one at a time on a valid/ready credit interface, which the countdown meter/display block consumes. This block is the sending end of that credit interface.

---
 rtl/coin_pkg.sv | 25 ++
 rtl/switch_debouncer.sv | 45 ++++
 rtl/coin_credit_tx.sv | 97 +++++++++
 tb/tb_coin_credit_tx.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/coin_pkg.sv
// Shared types and constants for the coin credit front end.
package coin_pkg;

  localparam int CREDIT_W = 5;

  localparam logic [CREDIT_W-1:0] CREDIT_SW0 = 5'd5;
  localparam logic [CREDIT_W-1:0] CREDIT_SW1 = 5'd10;
  localparam logic [CREDIT_W-1:0] CREDIT_SW2 = 5'd20;

  typedef enum logic [1:0] {
    COIN_5,
    COIN_10,
    COIN_20
  } coin_id_t;

  function automatic logic [CREDIT_W-1:0] coin_value(input coin_id_t id);
    case (id)
      COIN_5:  return CREDIT_SW0;
      COIN_10: return CREDIT_SW1;
      COIN_20: return CREDIT_SW2;
      default: return '0;
    endcase
  endfunction

endpackage

// File: rtl/switch_debouncer.sv
// Two-flop synchroniser, hold-time debouncer and rising-edge detector
// for one raw mechanical switch.
module switch_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic [CNT_W-1:0] cnt;
  logic             level_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_1  <= 1'b0;
      sync_2  <= 1'b0;
      cnt     <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync_1  <= raw;
      sync_2  <= sync_1;
      level_d <= level;
      if (sync_2 == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        level <= sync_2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign rise_pulse = level & ~level_d;

endmodule

// File: rtl/coin_credit_tx.sv
// Per-switch pending coin counters, fixed-priority arbiter and the
// registered valid/ready credit output.
module coin_credit_tx
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int PEND_MAX        = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sw0,
  input  logic                sw1,
  input  logic                sw2,
  input  logic                credit_ready,
  output logic                credit_valid,
  output logic [CREDIT_W-1:0] credit_amount,
  output logic                overflow
);

  localparam logic [1:0] PEND_LIM = 2'(PEND_MAX);

  logic [2:0]      raw;
  logic [2:0]      level;
  logic [2:0]      rise;
  logic [2:0]      pulse;
  logic [2:0][1:0] pend;
  logic [2:0]      dec;
  logic [2:0]      ovf_vec;
  logic            out_free;
  logic            any_pend;
  coin_id_t        sel_id;

  assign raw = {sw2, sw1, sw0};

  for (genvar g = 0; g < 3; g++) begin : g_sw
    switch_debouncer #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk       (clk),
      .rst       (rst),
      .raw       (raw[g]),
      .level     (level[g]),
      .rise_pulse(rise[g])
    );
  end

  assign pulse = rise & level;

  always_comb begin
    out_free = !credit_valid || credit_ready;
    any_pend = (pend[0] != 2'd0) || (pend[1] != 2'd0) || (pend[2] != 2'd0);
    sel_id   = COIN_5;
    dec      = 3'b000;
    if (pend[0] != 2'd0) begin
      sel_id = COIN_5;
      dec[0] = out_free;
    end else if (pend[1] != 2'd0) begin
      sel_id = COIN_10;
      dec[1] = out_free;
    end else if (pend[2] != 2'd0) begin
      sel_id = COIN_20;
      dec[2] = out_free;
    end
    for (int i = 0; i < 3; i++) begin
      ovf_vec[i] = pulse[i] && !dec[i] && (pend[i] == PEND_LIM);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend          <= '0;
      credit_valid  <= 1'b0;
      credit_amount <= '0;
      overflow      <= 1'b0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        case ({pulse[i], dec[i]})
          2'b10:   if (pend[i] != PEND_LIM) pend[i] <= pend[i] + 2'd1;
          2'b01:   pend[i] <= pend[i] - 2'd1;
          default: ;
        endcase
      end
      overflow <= |ovf_vec;
      // Output register only moves when empty or being accepted this cycle.
      if (out_free) begin
        if (any_pend) begin
          credit_valid  <= 1'b1;
          credit_amount <= coin_value(sel_id);
        end else begin
          credit_valid  <= 1'b0;
          credit_amount <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_coin_credit_tx.sv
// Directed bench for coin_credit_tx with a short debounce window.
module tb_coin_credit_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       sw0, sw1, sw2;
  logic       credit_ready;
  logic       credit_valid;
  logic [4:0] credit_amount;
  logic       overflow;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int vcyc = 0;
  int ovf_cnt = 0;
  int amts[$];
  int tcyc[$];

  coin_credit_tx #(
    .DEBOUNCE_CYCLES(4),
    .PEND_MAX       (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .sw0          (sw0),
    .sw1          (sw1),
    .sw2          (sw2),
    .credit_ready (credit_ready),
    .credit_valid (credit_valid),
    .credit_amount(credit_amount),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Observes the interface away from the active edge.
  always @(negedge clk) begin
    if (!rst) begin
      if (credit_valid) vcyc <= vcyc + 1;
      if (overflow) ovf_cnt <= ovf_cnt + 1;
      if (credit_valid && credit_ready) begin
        amts.push_back(int'(credit_amount));
        tcyc.push_back(cyc);
      end
    end
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int which, input int hi, input int lo);
    case (which)
      0: sw0 = 1'b1;
      1: sw1 = 1'b1;
      default: sw2 = 1'b1;
    endcase
    step(hi);
    case (which)
      0: sw0 = 1'b0;
      1: sw1 = 1'b0;
      default: sw2 = 1'b0;
    endcase
    step(lo);
  endtask

  int base_t, base_v, base_o;

  initial begin
    rst = 1'b1; sw0 = 1'b0; sw1 = 1'b0; sw2 = 1'b0; credit_ready = 1'b0;
    step(3);
    @(negedge clk);
    check("reset_valid", int'(credit_valid), 0);
    check("reset_amount", int'(credit_amount), 0);
    check("reset_overflow", int'(overflow), 0);
    step(1);
    rst = 1'b0;
    step(2);

    // single press of sw1
    credit_ready = 1'b1;
    base_t = amts.size(); base_v = vcyc;
    sw1 = 1'b1;
    step(20);
    check("press_transfers", amts.size() - base_t, 1);
    if (amts.size() > base_t) check("press_amount", amts[base_t], 10);
    check("press_valid_cycles", vcyc - base_v, 1);
    sw1 = 1'b0;
    step(20);
    check("release_no_credit", amts.size() - base_t, 1);

    // 3-cycle glitch on sw0 is rejected
    base_t = amts.size(); base_v = vcyc;
    press(0, 3, 20);
    check("glitch_transfers", amts.size() - base_t, 0);
    check("glitch_valid_cycles", vcyc - base_v, 0);

    // simultaneous presses drain in priority order, one per cycle
    base_t = amts.size();
    sw0 = 1'b1; sw1 = 1'b1; sw2 = 1'b1;
    step(20);
    sw0 = 1'b0; sw1 = 1'b0; sw2 = 1'b0;
    step(20);
    check("simul_transfers", amts.size() - base_t, 3);
    if (amts.size() >= base_t + 3) begin
      check("simul_amt0", amts[base_t], 5);
      check("simul_amt1", amts[base_t+1], 10);
      check("simul_amt2", amts[base_t+2], 20);
      check("simul_gap01", tcyc[base_t+1] - tcyc[base_t], 1);
      check("simul_gap12", tcyc[base_t+2] - tcyc[base_t+1], 1);
    end

    // backpressure holds the credit stable
    credit_ready = 1'b0;
    base_t = amts.size();
    sw2 = 1'b1;
    step(12);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("hold_valid_%0d", k), int'(credit_valid), 1);
      check($sformatf("hold_amount_%0d", k), int'(credit_amount), 20);
    end
    step(1);
    credit_ready = 1'b1;
    step(1);
    credit_ready = 1'b0;
    @(negedge clk);
    check("bp_valid_after", int'(credit_valid), 0);
    check("bp_amount_after", int'(credit_amount), 0);
    check("bp_transfers", amts.size() - base_t, 1);
    if (amts.size() > base_t) check("bp_amount", amts[base_t], 20);
    step(1);
    sw2 = 1'b0;
    step(20);
    check("bp_no_extra", amts.size() - base_t, 1);

    // saturation: 5 presses, output holds one, 3 pending, one dropped
    base_t = amts.size(); base_o = ovf_cnt;
    for (int k = 0; k < 5; k++) press(0, 10, 10);
    @(negedge clk);
    check("sat_overflow_pulses", ovf_cnt - base_o, 1);
    check("sat_valid", int'(credit_valid), 1);
    check("sat_amount", int'(credit_amount), 5);
    check("sat_no_transfer_yet", amts.size() - base_t, 0);
    step(1);
    credit_ready = 1'b1;
    step(10);
    check("sat_transfers", amts.size() - base_t, 4);
    for (int k = base_t; k < amts.size(); k++)
      check($sformatf("sat_amt_%0d", k - base_t), amts[k], 5);
    check("sat_valid_end", int'(credit_valid), 0);

    // reset while a credit is presented with 2 pending
    credit_ready = 1'b0;
    for (int k = 0; k < 3; k++) press(1, 10, 10);
    @(negedge clk);
    check("pre_rst_valid", int'(credit_valid), 1);
    check("pre_rst_amount", int'(credit_amount), 10);
    step(1);
    credit_ready = 1'b1;
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", int'(credit_valid), 0);
    check("rst_amount", int'(credit_amount), 0);
    base_t = amts.size(); base_v = vcyc;
    step(20);
    check("rst_no_transfers", amts.size() - base_t, 0);
    check("rst_no_valid", vcyc - base_v, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
